// File: rtl/axi_slave_responder_pkg.sv
// Shared types for the memory-backed AXI responder: bus bundles, FSM states,
// burst encodings and a size-clamping helper.
package axi_slave_responder_pkg;

  localparam int AXI_DW     = 8;
  localparam int AXI_AW     = 16;
  localparam int AXI_IDW    = 5;
  localparam int AXI_IDR    = 5;
  localparam int STRB_WIDTH = AXI_DW / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // Master-to-slave signals: AW, W, AR channels plus the B/R ready lines.
  typedef struct packed {
    logic                  aw_valid;
    logic [AXI_IDW-1:0]    aw_id;
    logic [AXI_AW-1:0]     aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  w_valid;
    logic [AXI_DW-1:0]     w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_last;
    logic                  b_ready;
    logic                  ar_valid;
    logic [AXI_IDR-1:0]    ar_id;
    logic [AXI_AW-1:0]     ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  r_ready;
  } axi_mosi_t;

  // Slave-to-master signals: address/data readies and the B/R channels.
  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic                  b_valid;
    logic [AXI_IDW-1:0]    b_id;
    logic [1:0]            b_resp;
    logic                  ar_ready;
    logic                  r_valid;
    logic [AXI_IDR-1:0]    r_id;
    logic [AXI_DW-1:0]     r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
  } axi_miso_t;

  // Limit AxSIZE to the widest beat the data bus can carry.
  function automatic logic [2:0] clamp_size(input logic [2:0] size, input int max_size);
    logic [2:0] res;
    res = size;
    if (int'(size) > max_size) res = 3'(max_size);
    return res;
  endfunction

endpackage

// File: rtl/axi_resp_mem.sv
// Byte-lane memory: one strobed write port, one asynchronous lane-wide read
// port. Lane addresses wrap modulo the array depth. Contents are not reset.
module axi_resp_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic [$clog2(MEM_DEPTH)-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]          rdata_o
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int MA_W  = $clog2(MEM_DEPTH);

  logic [7:0] mem_q [MEM_DEPTH];

  // Strobed byte writes; each lane lands at waddr + lane.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < LANES; l++) begin
        if (wstrb_i[l]) mem_q[waddr_i + MA_W'(l)] <= wdata_i[l*8 +: 8];
      end
    end
  end

  // Read lanes combinationally so a same-cycle write is seen one cycle later.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_rd_lane
    assign rdata_o[gi*8 +: 8] = mem_q[raddr_i + MA_W'(gi)];
  end

endmodule

// File: rtl/axi_slave_responder.sv
// Memory-backed AXI slave: independent write (AW/W/B) and read (AR/R) FSMs
// sharing one byte array, with burst counters and a sticky WLAST error flag.
module axi_slave_responder
  import axi_slave_responder_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = AXI_DW,
  parameter int ADDR_WIDTH     = AXI_AW,
  parameter int ID_W_WIDTH     = AXI_IDW,
  parameter int ID_R_WIDTH     = AXI_IDR,
  parameter int MEM_DEPTH      = 256
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  axi_mosi_t   s_axi_i,
  output axi_miso_t   s_axi_o,
  output logic [15:0] wr_bursts_o,
  output logic [15:0] rd_bursts_o,
  output logic        proto_err_o
);
  localparam int LANES    = AXI_DATA_WIDTH / 8;
  localparam int MAX_SIZE = $clog2(LANES);
  localparam int MA_W     = $clog2(MEM_DEPTH);

  wr_state_t             wr_state_q, wr_state_d;
  logic [ID_W_WIDTH-1:0] awid_q, awid_d;
  logic [MA_W-1:0]       waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic [8:0]            wbeat_q, wbeat_d;
  logic                  aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
  logic [15:0]           wr_bursts_q, wr_bursts_d;
  logic                  proto_err_q, proto_err_d;
  logic                  mem_we, w_last_beat;

  rd_state_t             rd_state_q, rd_state_d;
  logic [ID_R_WIDTH-1:0] rid_q, rid_d;
  logic [MA_W-1:0]       raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic [8:0]            rbeat_q, rbeat_d;
  logic                  ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
  logic [15:0]           rd_bursts_q, rd_bursts_d;
  logic                  r_last_beat;
  logic [AXI_DATA_WIDTH-1:0] mem_rdata;

  // Only the low address bits index the array; the rest are ignored.
  logic unused_ok;
  assign unused_ok = ^{s_axi_i.aw_addr, s_axi_i.ar_addr, ADDR_WIDTH[0]};

  assign w_last_beat = (wbeat_q == {1'b0, wlen_q});
  assign r_last_beat = (rbeat_q == {1'b0, rlen_q});

  // Write FSM next state: accept AW, store W beats, return B.
  always_comb begin
    wr_state_d  = wr_state_q;
    awid_d      = awid_q;
    waddr_d     = waddr_q;
    wlen_d      = wlen_q;
    wsize_d     = wsize_q;
    wburst_d    = wburst_q;
    wbeat_d     = wbeat_q;
    wr_bursts_d = wr_bursts_q;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (s_axi_i.aw_valid && aw_ready_q) begin
          awid_d     = s_axi_i.aw_id;
          waddr_d    = s_axi_i.aw_addr[MA_W-1:0];
          wlen_d     = s_axi_i.aw_len;
          wsize_d    = clamp_size(s_axi_i.aw_size, MAX_SIZE);
          wburst_d   = s_axi_i.aw_burst;
          wbeat_d    = '0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_i.w_valid && w_ready_q) begin
          mem_we  = 1'b1;
          wbeat_d = wbeat_q + 9'd1;
          // WRAP is handled like INCR; FIXED keeps hitting the same address.
          if (wburst_q != BURST_FIXED) waddr_d = waddr_q + (MA_W'(1) << wsize_q);
          // The AWLEN count is authoritative; a disagreeing WLAST only flags.
          if (s_axi_i.w_last != w_last_beat) proto_err_d = 1'b1;
          if (w_last_beat) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_valid_q && s_axi_i.b_ready) begin
          wr_state_d  = W_IDLE;
          wr_bursts_d = wr_bursts_q + 16'd1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    aw_ready_d = (wr_state_d == W_IDLE);
    w_ready_d  = (wr_state_d == W_DATA);
    b_valid_d  = (wr_state_d == W_RESP);
  end

  // Read FSM next state: accept AR, stream beats while RREADY is high.
  always_comb begin
    rd_state_d  = rd_state_q;
    rid_d       = rid_q;
    raddr_d     = raddr_q;
    rlen_d      = rlen_q;
    rsize_d     = rsize_q;
    rburst_d    = rburst_q;
    rbeat_d     = rbeat_q;
    rd_bursts_d = rd_bursts_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s_axi_i.ar_valid && ar_ready_q) begin
          rid_d      = s_axi_i.ar_id;
          raddr_d    = s_axi_i.ar_addr[MA_W-1:0];
          rlen_d     = s_axi_i.ar_len;
          rsize_d    = clamp_size(s_axi_i.ar_size, MAX_SIZE);
          rburst_d   = s_axi_i.ar_burst;
          rbeat_d    = '0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_valid_q && s_axi_i.r_ready) begin
          rbeat_d = rbeat_q + 9'd1;
          if (rburst_q != BURST_FIXED) raddr_d = raddr_q + (MA_W'(1) << rsize_q);
          if (r_last_beat) begin
            rd_state_d  = R_IDLE;
            rd_bursts_d = rd_bursts_q + 16'd1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    ar_ready_d = (rd_state_d == R_IDLE);
    r_valid_d  = (rd_state_d == R_DATA);
  end

  // State and payload registers; readies come up one cycle after reset release.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_state_q  <= W_IDLE;
      awid_q      <= '0;
      waddr_q     <= '0;
      wlen_q      <= '0;
      wsize_q     <= '0;
      wburst_q    <= '0;
      wbeat_q     <= '0;
      aw_ready_q  <= 1'b0;
      w_ready_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      wr_bursts_q <= '0;
      proto_err_q <= 1'b0;
      rd_state_q  <= R_IDLE;
      rid_q       <= '0;
      raddr_q     <= '0;
      rlen_q      <= '0;
      rsize_q     <= '0;
      rburst_q    <= '0;
      rbeat_q     <= '0;
      ar_ready_q  <= 1'b0;
      r_valid_q   <= 1'b0;
      rd_bursts_q <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      awid_q      <= awid_d;
      waddr_q     <= waddr_d;
      wlen_q      <= wlen_d;
      wsize_q     <= wsize_d;
      wburst_q    <= wburst_d;
      wbeat_q     <= wbeat_d;
      aw_ready_q  <= aw_ready_d;
      w_ready_q   <= w_ready_d;
      b_valid_q   <= b_valid_d;
      wr_bursts_q <= wr_bursts_d;
      proto_err_q <= proto_err_d;
      rd_state_q  <= rd_state_d;
      rid_q       <= rid_d;
      raddr_q     <= raddr_d;
      rlen_q      <= rlen_d;
      rsize_q     <= rsize_d;
      rburst_q    <= rburst_d;
      rbeat_q     <= rbeat_d;
      ar_ready_q  <= ar_ready_d;
      r_valid_q   <= r_valid_d;
      rd_bursts_q <= rd_bursts_d;
    end
  end

  axi_resp_mem #(
    .DATA_WIDTH(AXI_DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .waddr_i(waddr_q),
    .wdata_i(s_axi_i.w_data),
    .wstrb_i(s_axi_i.w_strb),
    .raddr_i(raddr_q),
    .rdata_o(mem_rdata)
  );

  // Drive the slave-side bus; RDATA is forced to zero whenever RVALID is low.
  always_comb begin
    s_axi_o          = '0;
    s_axi_o.aw_ready = aw_ready_q;
    s_axi_o.w_ready  = w_ready_q;
    s_axi_o.b_valid  = b_valid_q;
    s_axi_o.b_id     = awid_q;
    s_axi_o.ar_ready = ar_ready_q;
    s_axi_o.r_valid  = r_valid_q;
    s_axi_o.r_id     = rid_q;
    s_axi_o.r_data   = r_valid_q ? mem_rdata : '0;
    s_axi_o.r_last   = r_valid_q && r_last_beat;
  end

  assign wr_bursts_o = wr_bursts_q;
  assign rd_bursts_o = rd_bursts_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_axi_slave_responder.sv
// Randomized self-checking bench for axi_slave_responder against a byte-array
// reference model with burst-level address arithmetic.
module tb_axi_slave_responder;
  import axi_slave_responder_pkg::*;

  localparam int MEM_DEPTH = 256;
  localparam int MAX_SIZE  = $clog2(STRB_WIDTH);

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  axi_mosi_t   mosi;
  axi_miso_t   miso;
  logic [15:0] wr_bursts_o, rd_bursts_o;
  logic        proto_err_o;

  int n_compared = 0;
  int n_mismatch = 0;

  logic [7:0]            mem_model [MEM_DEPTH];
  int                    exp_wr = 0;
  int                    exp_rd = 0;
  logic                  exp_err = 1'b0;
  logic [AXI_DW-1:0]     wr_data [256];
  logic [STRB_WIDTH-1:0] wr_strb [256];

  axi_slave_responder #(
    .AXI_DATA_WIDTH(AXI_DW),
    .ADDR_WIDTH    (AXI_AW),
    .ID_W_WIDTH    (AXI_IDW),
    .ID_R_WIDTH    (AXI_IDR),
    .MEM_DEPTH     (MEM_DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .s_axi_i    (mosi),
    .s_axi_o    (miso),
    .wr_bursts_o(wr_bursts_o),
    .rd_bursts_o(rd_bursts_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Byte address of beat i of a burst, straight from the burst rules.
  function automatic int beat_addr(input int base, input int i, input int size, input int burst);
    int s;
    s = (size > MAX_SIZE) ? MAX_SIZE : size;
    if (burst == 0) return base % MEM_DEPTH;
    return (base + i * (1 << s)) % MEM_DEPTH;
  endfunction

  function automatic logic [AXI_DW-1:0] exp_rdata(input int a);
    logic [AXI_DW-1:0] v;
    for (int l = 0; l < STRB_WIDTH; l++) v[l*8 +: 8] = mem_model[(a + l) % MEM_DEPTH];
    return v;
  endfunction

  // One write burst using wr_data/wr_strb; WLAST is inverted on beat bad_beat.
  task automatic write_burst(input int id, input int addr, input int len, input int size,
                             input int burst, input int bad_beat, input bit gaps);
    int guard;
    int a;
    mosi.aw_valid = 1'b1;
    mosi.aw_id    = AXI_IDW'(id);
    mosi.aw_addr  = AXI_AW'(addr);
    mosi.aw_len   = 8'(len);
    mosi.aw_size  = 3'(size);
    mosi.aw_burst = 2'(burst);
    guard = 0;
    while (!miso.aw_ready && guard < 100) begin step(); guard++; end
    check_eq("aw_ready_wait", 32'(miso.aw_ready), 32'd1);
    step();
    mosi.aw_valid = 1'b0;
    check_eq("w_ready_after_aw", 32'(miso.w_ready), 32'd1);
    for (int i = 0; i <= len; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      mosi.w_valid = 1'b1;
      mosi.w_data  = wr_data[i];
      mosi.w_strb  = wr_strb[i];
      mosi.w_last  = (i == len) ^ (i == bad_beat);
      guard = 0;
      while (!miso.w_ready && guard < 100) begin step(); guard++; end
      check_eq("w_ready_beat", 32'(miso.w_ready), 32'd1);
      step();
      mosi.w_valid = 1'b0;
      a = beat_addr(addr, i, size, burst);
      for (int l = 0; l < STRB_WIDTH; l++)
        if (wr_strb[i][l]) mem_model[(a + l) % MEM_DEPTH] = wr_data[i][l*8 +: 8];
      if (i < len) check_eq("b_valid_mid", 32'(miso.b_valid), 32'd0);
    end
    if (bad_beat >= 0) exp_err = 1'b1;
    check_eq("b_valid_after_last", 32'(miso.b_valid), 32'd1);
    check_eq("b_id", 32'(miso.b_id), 32'(id));
    if (gaps) repeat ($urandom_range(0, 3)) step();
    check_eq("b_valid_held", 32'(miso.b_valid), 32'd1);
    mosi.b_ready = 1'b1;
    step();
    mosi.b_ready = 1'b0;
    exp_wr++;
    check_eq("aw_ready_after_b", 32'(miso.aw_ready), 32'd1);
    check_eq("wr_bursts", 32'(wr_bursts_o), 32'(exp_wr & 16'hFFFF));
    check_eq("proto_err", 32'(proto_err_o), 32'(exp_err));
    $display("WR id=%0d addr=0x%0h len=%0d size=%0d burst=%0d bad_beat=%0d", id, addr, len, size, burst, bad_beat);
  endtask

  // One read burst; mode 0 = RREADY always 1, 1 = toggle 1,0,..., 2 = random.
  task automatic read_burst(input int id, input int addr, input int len, input int size,
                            input int burst, input int mode);
    int guard;
    int i;
    int cyc;
    logic rr;
    mosi.ar_valid = 1'b1;
    mosi.ar_id    = AXI_IDR'(id);
    mosi.ar_addr  = AXI_AW'(addr);
    mosi.ar_len   = 8'(len);
    mosi.ar_size  = 3'(size);
    mosi.ar_burst = 2'(burst);
    guard = 0;
    while (!miso.ar_ready && guard < 100) begin step(); guard++; end
    check_eq("ar_ready_wait", 32'(miso.ar_ready), 32'd1);
    step();
    mosi.ar_valid = 1'b0;
    check_eq("r_valid_after_ar", 32'(miso.r_valid), 32'd1);
    i = 0;
    cyc = 0;
    while (i <= len && cyc < 2000) begin
      check_eq("r_valid", 32'(miso.r_valid), 32'd1);
      check_eq("r_id", 32'(miso.r_id), 32'(id));
      check_eq("r_data", 32'(miso.r_data), 32'(exp_rdata(beat_addr(addr, i, size, burst))));
      check_eq("r_last", 32'(miso.r_last), 32'(i == len));
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      mosi.r_ready = rr;
      step();
      if (rr) i++;
      cyc++;
    end
    mosi.r_ready = 1'b0;
    check_eq("r_beats", 32'(i), 32'(len + 1));
    exp_rd++;
    check_eq("r_valid_after_last", 32'(miso.r_valid), 32'd0);
    check_eq("ar_ready_after_last", 32'(miso.ar_ready), 32'd1);
    check_eq("rd_bursts", 32'(rd_bursts_o), 32'(exp_rd & 16'hFFFF));
    $display("RD id=%0d addr=0x%0h len=%0d size=%0d burst=%0d mode=%0d", id, addr, len, size, burst, mode);
  endtask

  initial begin
    logic [7:0] old0, old1, nd;
    mosi = '0;

    // Reset behaviour and ready rise one cycle after release.
    repeat (3) step();
    check_eq("rst_aw_ready", 32'(miso.aw_ready), 32'd0);
    check_eq("rst_ar_ready", 32'(miso.ar_ready), 32'd0);
    check_eq("rst_b_valid", 32'(miso.b_valid), 32'd0);
    check_eq("rst_r_valid", 32'(miso.r_valid), 32'd0);
    check_eq("rst_counters", 32'({wr_bursts_o, rd_bursts_o}), 32'd0);
    check_eq("rst_proto_err", 32'(proto_err_o), 32'd0);
    arstn_i = 1'b1;
    #1;
    check_eq("rel_aw_ready_0", 32'(miso.aw_ready), 32'd0);
    step();
    check_eq("rel_aw_ready_1", 32'(miso.aw_ready), 32'd1);
    check_eq("rel_ar_ready_1", 32'(miso.ar_ready), 32'd1);
    $display("RESET released");

    // Prefill the whole array so every later read has defined data.
    for (int b = 0; b < MEM_DEPTH / 16; b++) begin
      for (int i = 0; i < 16; i++) begin
        wr_data[i] = AXI_DW'($urandom);
        wr_strb[i] = '1;
      end
      write_burst(b % 32, b * 16, 15, 0, 1, -1, 1'b0);
    end

    // Directed write 0xA0..0xA3 to 0x10, then read back with RREADY toggling.
    for (int i = 0; i < 4; i++) begin
      wr_data[i] = AXI_DW'(8'hA0 + i);
      wr_strb[i] = '1;
    end
    write_burst(3, 16'h10, 3, 0, 1, -1, 1'b0);
    read_burst(7, 16'h10, 3, 0, 1, 1);

    // Early WLAST on a two-beat burst: error flag set, burst still 2 beats.
    wr_data[0] = 8'h11; wr_data[1] = 8'h22; wr_strb[0] = '1; wr_strb[1] = '1;
    write_burst(5, 16'h30, 1, 0, 1, 0, 1'b0);
    read_burst(6, 16'h30, 1, 0, 1, 0);

    // Address wrap at the top of the array.
    wr_data[0] = 8'h55; wr_data[1] = 8'h66;
    write_burst(9, MEM_DEPTH - 1, 1, 0, 1, -1, 1'b0);
    read_burst(10, 0, 0, 0, 1, 0);
    read_burst(11, MEM_DEPTH - 1, 1, 0, 1, 0);

    // FIXED burst: every beat hits 0x20, last one wins.
    for (int i = 0; i < 3; i++) wr_data[i] = AXI_DW'(i + 1);
    write_burst(12, 16'h20, 2, 0, 0, -1, 1'b0);
    read_burst(13, 16'h20, 0, 0, 1, 0);

    // Randomized mix of bursts, sizes, burst types, strobes and stalls.
    for (int t = 0; t < 30; t++) begin
      int len, addr, size, burst;
      len   = $urandom_range(0, 15);
      addr  = $urandom_range(0, 16'hFFFF);
      size  = $urandom_range(0, 7);
      burst = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin
          wr_data[i] = AXI_DW'($urandom);
          wr_strb[i] = STRB_WIDTH'($urandom);
        end
        write_burst($urandom_range(0, 31), addr, len, size, burst, -1, 1'b1);
      end else begin
        read_burst($urandom_range(0, 31), addr, len, size, burst, 2);
      end
    end

    // Concurrent write and read to 0x40, then reset in the middle of the read.
    old0 = mem_model[8'h40];
    old1 = mem_model[8'h41];
    nd   = ~old0;
    mosi.aw_valid = 1'b1; mosi.aw_id = 5'd1; mosi.aw_addr = 16'h40; mosi.aw_len = 8'd0;
    mosi.aw_size = 3'd0; mosi.aw_burst = 2'd1;
    mosi.ar_valid = 1'b1; mosi.ar_id = 5'd2; mosi.ar_addr = 16'h40; mosi.ar_len = 8'd3;
    mosi.ar_size = 3'd0; mosi.ar_burst = 2'd1;
    check_eq("cc_aw_ready", 32'(miso.aw_ready), 32'd1);
    check_eq("cc_ar_ready", 32'(miso.ar_ready), 32'd1);
    step();
    mosi.aw_valid = 1'b0;
    mosi.ar_valid = 1'b0;
    mosi.w_valid = 1'b1; mosi.w_data = nd; mosi.w_strb = '1; mosi.w_last = 1'b1;
    mosi.r_ready = 1'b1;
    check_eq("cc_r_data_old", 32'(miso.r_data), 32'(old0));
    step();
    mosi.w_valid = 1'b0;
    mosi.r_ready = 1'b0;
    mem_model[8'h40] = nd;
    check_eq("cc_b_valid", 32'(miso.b_valid), 32'd1);
    check_eq("cc_r_data_beat1", 32'(miso.r_data), 32'(old1));
    arstn_i = 1'b0;
    #1;
    exp_wr = 0; exp_rd = 0; exp_err = 1'b0;
    check_eq("mid_rst_r_valid", 32'(miso.r_valid), 32'd0);
    check_eq("mid_rst_b_valid", 32'(miso.b_valid), 32'd0);
    check_eq("mid_rst_r_data", 32'(miso.r_data), 32'd0);
    check_eq("mid_rst_readies", 32'({miso.aw_ready, miso.ar_ready}), 32'd0);
    check_eq("mid_rst_wr_bursts", 32'(wr_bursts_o), 32'd0);
    check_eq("mid_rst_rd_bursts", 32'(rd_bursts_o), 32'd0);
    check_eq("mid_rst_proto_err", 32'(proto_err_o), 32'd0);
    $display("RESET pulsed mid-read");
    step();
    step();
    arstn_i = 1'b1;
    step();
    check_eq("post_rst_aw_ready", 32'(miso.aw_ready), 32'd1);
    check_eq("post_rst_ar_ready", 32'(miso.ar_ready), 32'd1);
    check_eq("post_rst_r_valid", 32'(miso.r_valid), 32'd0);
    read_burst(4, 16'h40, 1, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/axi_slave_responder.md
# axi_slave_responder

Memory-backed AXI slave that terminates traffic from `axi_master_loader`. It accepts AW/W bursts into an internal byte array and returns B responses. It accepts AR requests and returns R bursts read from the same array. It sits on the far side of the NoC, or directly on a loader in unit benches, and exports burst counters and a sticky protocol-error flag for PMU cross-checking.

## Interface
Parameters:
- AXI_DATA_WIDTH, 8: data bus width in bits. Must be 8 × 2^k.
- ADDR_WIDTH, 16: AxADDR width.
- ID_W_WIDTH, 5: AWID/BID width.
- ID_R_WIDTH, 5: ARID/RID width.
- MEM_DEPTH, 256: array size in bytes. Must be a power of two.

Ports:
- clk_i  in  1  clock. One clock domain.
- arstn_i  in  1  reset, asynchronous, active-low.
- s_axi_i  in  axi_mosi_t  AW/W/AR channels plus BREADY/RREADY from the master.
- s_axi_o  out  axi_miso_t  AWREADY, WREADY, ARREADY, and the B/R channels to the master.
- wr_bursts_o  out  16  completed write bursts (B handshakes). Wraps at 2^16.
- rd_bursts_o  out  16  completed read bursts (RLAST handshakes). Wraps at 2^16.
- proto_err_o  out  1  sticky flag. Set on a WLAST/AWLEN mismatch. Cleared only by reset.

## Operation
- Write and read paths are independent FSMs and run concurrently.
- Write FSM states: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: AWREADY=1. On AW handshake, latch AWID, AWADDR, AWLEN, AWSIZE and AWBURST; clear the beat counter.
  - W_DATA: WREADY=1. On each W handshake, write each byte lane whose WSTRB bit is 1 to mem[waddr + lane].
  - Beat address: INCR adds 2^AWSIZE; FIXED holds; WRAP is treated as INCR.
  - Address arithmetic is modulo MEM_DEPTH.
  - The burst ends on beat number AWLEN. If WLAST ≠ (beat == AWLEN), set proto_err_o and still end the burst on the AWLEN count.
  - W_RESP: BVALID=1 with BID set to the latched AWID. Hold BVALID until BREADY, then return to W_IDLE and increment wr_bursts_o.
- Read FSM states: R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ARREADY=1. On AR handshake, latch ARID, ARADDR, ARLEN, ARSIZE and ARBURST.
  - R_DATA: RVALID=1, RID set to the latched ARID, RDATA = mem[raddr .. raddr+lanes-1], RLAST = (beat == ARLEN).
  - Address and beat advance on each RREADY. The last handshake returns to R_IDLE and increments rd_bursts_o.
- Memory contents are not reset. A bench must write an address before reading it.
- Width rule: AxLEN is 8 bits, so the beat counter is 9 bits wide. AxSIZE values above log2(AXI_DATA_WIDTH/8) are clamped to that value.

## Timing
- Reset values: every ready/valid is 0, RLAST=0, BID/RID/RDATA=0, counters=0, proto_err_o=0, both FSMs in IDLE.
- AWREADY and ARREADY are registered. They rise in the first cycle after arstn_i deasserts.
- AW handshake in cycle N: WREADY=1 from N+1. The first W beat can be accepted in N+1.
- Final W beat in cycle M: BVALID=1 in M+1.
- B handshake in cycle P: AWREADY=1 in P+1. Minimum write turnaround is AWLEN+3 cycles.
- AR handshake in cycle N: RVALID=1 from N+1. Beats stream back-to-back while RREADY=1.
- After the RLAST handshake, ARREADY=1 on the next cycle.
- Valid and payload stay stable while stalled; no channel drops VALID without its handshake.
- Simultaneous write beat and read beat to the same address: the read returns the old data (read-before-write). The write is visible one cycle later.
- W beats arriving in W_IDLE are not accepted (WREADY=0), so they cannot be consumed early.
- Reset mid-burst: both FSMs abort to IDLE immediately; no B or R is produced for the aborted burst.

## Structure
- axi_type.svh: axi_mosi_t and axi_miso_t. Shared with the loader and reused unchanged.
- Responder package: state enums wr_state_t {W_IDLE, W_DATA, W_RESP} and rd_state_t {R_IDLE, R_DATA}, and a localparam STRB_WIDTH = AXI_DATA_WIDTH/8.
- One sub-module, axi_resp_mem: byte-lane memory with one write port and one asynchronous read port, MEM_DEPTH bytes, lane-wide access.

## Test plan
- Reset release → AWREADY=ARREADY=1 exactly one cycle later. All valids 0 and counters 0 during reset.
- AW id=3, addr=0x10, len=3, size=0, INCR; W data 0xA0–0xA3; BREADY=1 → BVALID with BID=3 one cycle after WLAST; wr_bursts_o=1.
- AR id=7, addr=0x10, len=3 with RREADY toggled 1,0,1,0 → RDATA sequence 0xA0–0xA3 with RID=7; RLAST only on beat 3; payload stable while stalled; rd_bursts_o=1.
- AW len=1 but WLAST asserted on beat 0 → burst ends after 2 beats; proto_err_o=1 and stays 1; B returned normally.
- Write addr=MEM_DEPTH-1 with len=1 → second byte lands at address 0. FIXED burst len=2 to 0x20 with data 1,2,3 → mem[0x20]=3.
- Concurrent write and read burst to the same address, then arstn_i pulsed mid-read → the read returns the old value; after reset both FSMs are idle, RVALID=0 and counters=0.
